// File: rtl/parity_frame_rx_if.sv
// Bus bundle for the parity-framed serial receiver: line/strobe/clear inputs
// and the received-nibble and error-reporting outputs.
interface parity_frame_rx_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 serial_in;
  logic                 bit_en;
  logic                 err_clr;
  logic [3:0]           data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output serial_in, bit_en, err_clr,
    input  data_out, data_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  serial_in, bit_en, err_clr,
    output data_out, data_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Receives start/D3..D0/even-parity/stop frames sampled on bit_en strobes,
// reporting each nibble and counting parity/framing errors (saturating).
module parity_frame_rx #(
  parameter int ERR_CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  parity_frame_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [1:0]           bit_cnt, bit_cnt_next;
  logic [3:0]           shift, shift_next;
  logic                 par_bit, par_bit_next;
  logic [3:0]           data_q, data_next;
  logic                 valid_q, valid_next;
  logic                 perr_q, perr_next;
  logic                 ferr_q, ferr_next;
  logic [ERR_CNT_W-1:0] err_cnt, err_cnt_next;
  logic                 err_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 2'd0;
      shift   <= 4'h0;
      par_bit <= 1'b0;
      data_q  <= 4'h0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
      par_bit <= par_bit_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      perr_q  <= perr_next;
      ferr_q  <= ferr_next;
      err_cnt <= err_cnt_next;
    end
  end

  // Pulses default low every cycle so they last exactly one clock.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_bit_next = par_bit;
    data_next    = data_q;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    err_event    = 1'b0;
    err_cnt_next = err_cnt;

    if (bus.bit_en) begin
      case (state)
        IDLE: begin
          if (!bus.serial_in) begin
            state_next   = DATA;
            bit_cnt_next = 2'd0;
          end
        end
        DATA: begin
          shift_next   = {shift[2:0], bus.serial_in};
          bit_cnt_next = bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          par_bit_next = bus.serial_in;
          state_next   = STOP;
        end
        STOP: begin
          // A low stop bit is a framing error and never doubles as a start bit.
          state_next = IDLE;
          if (bus.serial_in) begin
            data_next  = shift;
            valid_next = 1'b1;
            perr_next  = ^{shift, par_bit};
            err_event  = perr_next;
          end else begin
            ferr_next = 1'b1;
            err_event = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (bus.err_clr) begin
      err_cnt_next = '0;
    end else if (err_event && (err_cnt != '1)) begin
      err_cnt_next = err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);
  assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: two instances (8-bit and 2-bit error
// counters) share one stimulus stream; a scoreboard predicts every pulse.
module tb_parity_frame_rx;

  logic clk;
  logic rst;

  parity_frame_rx_if #(.ERR_CNT_W(8)) bus8 ();
  parity_frame_rx_if #(.ERR_CNT_W(2)) bus2 ();

  assign bus2.serial_in = bus8.serial_in;
  assign bus2.bit_en    = bus8.bit_en;
  assign bus2.err_clr   = bus8.err_clr;

  parity_frame_rx #(.ERR_CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  parity_frame_rx #(.ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] model_data = 4'h0;
  logic [7:0] model_c8   = 8'd0;
  logic [1:0] model_c2   = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pulse cycle consumes exactly one prediction; stray or stretched pulses find an empty queue.
  always @(negedge clk) begin
    if (bus8.data_valid || bus8.parity_err || bus8.frame_err ||
        bus2.data_valid || bus2.parity_err || bus2.frame_err) begin
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data_out",     32'(bus8.data_out),   32'(e.data));
        check("data_valid",   32'(bus8.data_valid), 32'(e.valid));
        check("parity_err",   32'(bus8.parity_err), 32'(e.perr));
        check("frame_err",    32'(bus8.frame_err),  32'(e.ferr));
        check("err_count8",   32'(bus8.err_count),  32'(e.c8));
        check("w2_data_out",  32'(bus2.data_out),   32'(e.data));
        check("w2_valid",     32'(bus2.data_valid), 32'(e.valid));
        check("w2_parity",    32'(bus2.parity_err), 32'(e.perr));
        check("w2_frame",     32'(bus2.frame_err),  32'(e.ferr));
        check("err_count2",   32'(bus2.err_count),  32'(e.c2));
      end
    end
  end

  task automatic send_bit(input logic b, input int stride, input logic exp_busy);
    bus8.serial_in = b;
    bus8.bit_en    = 1'b1;
    @(posedge clk);
    #1;
    bus8.bit_en  = 1'b0;
    bus8.err_clr = 1'b0;
    check("busy", 32'(bus8.busy), 32'(exp_busy));
    for (int k = 1; k < stride; k++) begin
      bus8.serial_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("busy_hold", 32'(bus8.busy), 32'(exp_busy));
    end
  endtask

  // Frame bits listed start-first: {start, D3, D2, D1, D0, P, stop}.
  task automatic send_frame(input logic [6:0] f, input int stride, input logic clr);
    exp_t e;
    for (int i = 6; i >= 0; i--) begin
      if (i == 0) begin
        e.valid = f[0];
        e.ferr  = ~f[0];
        e.perr  = f[0] & (^f[5:1]);
        if (f[0]) model_data = f[5:2];
        e.data = model_data;
        if (e.perr || e.ferr) begin
          if (model_c8 != 8'hFF) model_c8 = model_c8 + 8'd1;
          if (model_c2 != 2'd3)  model_c2 = model_c2 + 2'd1;
        end
        if (clr) begin
          model_c8 = 8'd0;
          model_c2 = 2'd0;
        end
        e.c8 = model_c8;
        e.c2 = model_c2;
        sb.push_back(e);
        bus8.err_clr = clr;
      end
      send_bit(f[i], stride, (i != 0));
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus8.serial_in = 1'b1;
    bus8.bit_en    = 1'b1;
    bus8.err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out",  32'(bus8.data_out),   32'h0);
    check("rst_valid",     32'(bus8.data_valid), 32'h0);
    check("rst_busy",      32'(bus8.busy),       32'h0);
    check("rst_err_count", 32'(bus8.err_count),  32'h0);
    rst = 1'b0;

    // Idle line must not start a frame.
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);

    // Good, bad-parity and framing-error frames back to back.
    send_frame(7'b0101111, 1, 1'b0);
    send_frame(7'b0101101, 1, 1'b0);
    send_frame(7'b0011000, 1, 1'b0);
    check("idle_after_ferr", 32'(bus8.busy), 32'h0);

    // Slow strobes: state holds between bit_en edges.
    send_frame(7'b0101111, 3, 1'b0);

    // Abort mid-frame with reset after the third data bit.
    send_bit(1'b0, 1, 1'b1);
    send_bit(1'b0, 1, 1'b1);
    send_bit(1'b1, 1, 1'b1);
    send_bit(1'b1, 1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    model_data = 4'h0;
    model_c8   = 8'd0;
    model_c2   = 2'd0;
    check("abort_data_out", 32'(bus8.data_out),  32'h0);
    check("abort_busy",     32'(bus8.busy),      32'h0);
    check("abort_err_cnt",  32'(bus8.err_count), 32'h0);
    send_frame(7'b0011001, 1, 1'b0);

    // Saturation of the narrow counter, then clear winning over an error.
    for (int n = 0; n < 5; n++) send_frame(7'b0011011, 2, 1'b0);
    check("sat_err_count2", 32'(bus2.err_count), 32'd3);
    check("sat_err_count8", 32'(bus8.err_count), 32'd5);
    send_frame(7'b0011011, 1, 1'b1);
    check("clr_err_count2", 32'(bus2.err_count), 32'd0);
    check("clr_err_count8", 32'(bus8.err_count), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
